wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (wen/wraddr/wrdata, gated by hold) between NREQ write-back sources: ALU, LSU and MDU.
- Round-robin arbitration with valid/ready handshakes.
- One registered output stage drives the register file directly.
- Guarantees that wen is never asserted for x0, so the register file's write-to-read bypass cannot forward a bogus x0 value.

Parameters:
- NREQ, 3, number of write-back requesters; 2 to 8.
- CNT_W, 16, width of each conflict counter; used only with WB_PERF_CNT_EN.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- hold  input  1  pipeline hold; same signal the register file uses to block writes
- flush  input  1  synchronous flush; discards the staged write
- req_valid  input  NREQ  requester i has a write pending
- req_ready  output  NREQ  requester i accepted this cycle
- req_addr  input  NREQ*5  destination register; slice i = [5i+4:5i]
- req_data  input  NREQ*32  write data; slice i = [32i+31:32i]
- rf_wen  output  1  to register-file wen
- rf_wraddr  output  5  to register-file wraddr
- rf_wrdata  output  32  to register-file wrdata
- busy  output  1  a staged write is pending (equals rf_wen)
- conflict_cnt  output  NREQ*CNT_W  per-requester stall counters; present only with WB_PERF_CNT_EN

Behaviour:
- Reset (async, rst_n=0):
  - rf_wen=0, rf_wraddr=0, rf_wrdata=0.
  - Round-robin pointer ptr=0.
  - All counters 0.
  - req_ready is combinational: 0 while rst_n=0.
- Arbitration (combinational):
  - Scan req_valid starting at index ptr, wrapping modulo NREQ; the first valid index is the winner g.
  - req_ready[g]=1 only when hold=0, flush=0 and some request is valid. All other ready bits are 0.
  - req_ready may depend on req_valid. Requesters must hold valid, addr and data stable until ready.
- Pointer:
  - On an accepted grant, ptr <= (g+1) mod NREQ at the clock edge.
  - Otherwise ptr holds. Flush does not change ptr.
- Output stage, evaluated at each posedge in priority order:
  1. flush=1: rf_wen<=0. addr and data hold. No grant that cycle. Flush overrides hold.
  2. hold=1: all output registers hold. A write staged before hold stays presented until hold drops, because the register file ignores writes while hold=1.
  3. Grant accepted: rf_wraddr<=addr_g, rf_wrdata<=data_g, rf_wen<=(addr_g!=0).
  4. No valid request: rf_wen<=0. addr and data hold.
- Latency: exactly 1 cycle from acceptance (valid&ready at edge N) to rf_wen=1 in cycle N+1.
- Throughput: 1 write per cycle while hold=0. Back-to-back grants keep rf_wen high continuously.
- x0 write: the request is accepted and consumed, but rf_wen=0 for that slot and ptr still advances.
- Simultaneous requests: served in rotating order. No requester waits more than NREQ-1 grants.
- Reset mid-operation: the staged write is lost; requesters re-present.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- When defined:
  - conflict_cnt[i] increments by 1 each cycle that req_valid[i]=1 and req_ready[i]=0 with hold=0 and flush=0.
  - Counters saturate at all-ones.
  - Cleared only by reset.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- defines.v gains:
  - WB_NREQ = 3.
  - Requester indices WB_ALU=0, WB_LSU=1, WB_MDU=2.
  - Width macros for register address (5) and register data (32).
- One sub-module: rr_pick.
  - Inputs: NREQ-bit valid vector and ptr.
  - Outputs: one-hot grant plus winner index.
  - Purely combinational; instantiated once.

Test Plan:
- Single ALU request, addr=5, data=0xDEADBEEF, hold=0 -> ready[0]=1 same cycle; next cycle rf_wen=1, rf_wraddr=5, rf_wrdata=0xDEADBEEF; following cycle rf_wen=0.
- All three valid continuously (addrs 1/2/3), ptr=0 -> grants in order 0,1,2,0; rf_wen held high; rf_wraddr sequence 1,2,3,1.
- LSU request addr=0, data=0x1234 -> ready[1]=1; next cycle rf_wen=0; ptr advances to 2.
- Write staged (addr=7, data=0xA5) then hold=1 for 3 cycles with MDU valid -> rf_wen=1, addr=7, data=0xA5 stable for all 3 cycles; ready stays 0; after hold drops, the MDU write is staged next.
- flush asserted while rf_wen=1 and hold=1 -> next cycle rf_wen=0; no ready asserted in the flush cycle.
- With WB_PERF_CNT_EN: ALU and LSU valid for 4 cycles, ptr=0, no hold/flush -> conflict_cnt[0]=2 and conflict_cnt[1]=2 after the 4 cycles; rst_n pulse low returns both to 0 asynchronously.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, requester indices and the staged-write payload for the write-back port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    localparam int unsigned WB_NREQ = 3;
    localparam int unsigned WB_ALU  = 0;
    localparam int unsigned WB_LSU  = 1;
    localparam int unsigned WB_MDU  = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_wr_t;

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping modulo NREQ.
module wb_port_arbiter_rr_pick #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int unsigned cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr_i) + k) % NREQ;
            if (!any_o && valid_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = IDX_W'(cand);
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ write-back sources.
// Optional per-requester stall counters are built when WB_PERF_CNT_EN is defined.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = WB_NREQ,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hold,
    input  logic                       flush,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NREQ*REG_DATA_W-1:0] req_data,
    output logic                       rf_wen,
    output logic [REG_ADDR_W-1:0]      rf_wraddr,
    output logic [REG_DATA_W-1:0]      rf_wrdata,
    output logic                       busy
`ifdef WB_PERF_CNT_EN
    ,
    output logic [NREQ*CNT_W-1:0]      conflict_cnt
`endif
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || CNT_W < 1) begin : g_param_err
        $error("wb_port_arbiter: NREQ must be 2..8 and CNT_W at least 1");
    end

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             wen_q, wen_d;
    wb_wr_t           wr_q, wr_d;

    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] win_idx;
    logic             any_valid;
    logic             accept;
    wb_wr_t           win_wr;

    wb_port_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (any_valid)
    );

    // Ready is forced low during reset so no requester retires a write that would be lost.
    assign accept    = rst_n && any_valid && !hold && !flush;
    assign req_ready = accept ? grant : '0;

    assign win_wr.addr = req_addr[32'(win_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign win_wr.data = req_data[32'(win_idx)*REG_DATA_W +: REG_DATA_W];

    // Output stage priority: flush, hold, grant, idle.
    always_comb begin
        ptr_d = ptr_q;
        wen_d = wen_q;
        wr_d  = wr_q;
        if (flush) begin
            wen_d = 1'b0;
        end else if (hold) begin
            wen_d = wen_q;
        end else if (any_valid) begin
            wr_d  = win_wr;
            wen_d = (win_wr.addr != '0);
            ptr_d = (win_idx == IDX_W'(NREQ-1)) ? '0 : win_idx + IDX_W'(1);
        end else begin
            wen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            wen_q <= 1'b0;
            wr_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            wen_q <= wen_d;
            wr_q  <= wr_d;
        end
    end

    assign rf_wen    = wen_q;
    assign rf_wraddr = wr_q.addr;
    assign rf_wrdata = wr_q.data;
    assign busy      = wen_q;

`ifdef WB_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q [NREQ];
    logic [CNT_W-1:0] cnt_d [NREQ];

    // Saturating count of cycles a requester was valid but lost arbitration.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (req_valid[i] && !req_ready[i] && !hold && !flush && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_out
        assign conflict_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
`endif

endmodule
